// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch controller and its instruction queue.
package fetch_pkg;
`include "defines.svh"

    localparam int PC_W        = `PC_W;
    localparam int REG_W       = `REG_W;
    localparam int FETCH_WIDTH = 4;
    localparam int DEQ_WIDTH   = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        `PC        pc;
        `REG_WIDTH inst;
    } iq_entry_t;

endpackage

// File: rtl/defines.svh
// Shared width macros for the fetch path.
`ifndef FETCH_DEFINES_SVH
`define FETCH_DEFINES_SVH
`define PC_W 32
`define REG_W 32
`define PC logic [`PC_W-1:0]
`define REG_WIDTH logic [`REG_W-1:0]
`endif

// File: rtl/fetch_ctrl_inst_queue.sv
// Circular instruction queue: four entries written per push, two read ports at the head.
module inst_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic                                enq_i,
    input  logic [FETCH_WIDTH-1:0][PC_W-1:0]    enq_pc_i,
    input  logic [FETCH_WIDTH-1:0][REG_W-1:0]   enq_inst_i,
    input  logic [1:0]                          deq_num_i,
    output logic [DEQ_WIDTH-1:0][PC_W-1:0]      rd_pc_o,
    output logic [DEQ_WIDTH-1:0][REG_W-1:0]     rd_inst_o,
    output logic [$clog2(DEPTH):0]              count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    iq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(deq_num_i);
            tail_d  = enq_i ? tail_q + AW'(FETCH_WIDTH) : tail_q;
            count_d = count_q - CW'(deq_num_i) + (enq_i ? CW'(FETCH_WIDTH) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (enq_i && !flush_i) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                mem_q[tail_q + AW'(k)] <= '{pc: enq_pc_i[k], inst: enq_inst_i[k]};
            end
        end
    end

    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_rd
        assign rd_pc_o[i]   = mem_q[head_q + AW'(i)].pc;
        assign rd_inst_o[i] = mem_q[head_q + AW'(i)].inst;
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller: PC sequencing, redirect handling and decode-slot presentation.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              IQ_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic [PC_W-1:0]                    icache_pc,
    input  logic [FETCH_WIDTH-1:0][REG_W-1:0]  icache_inst,
    input  logic                               redirect_valid,
    input  logic [PC_W-1:0]                    redirect_pc,
    output logic [1:0]                         out_valid,
    output logic [DEQ_WIDTH-1:0][REG_W-1:0]    out_inst,
    output logic [DEQ_WIDTH-1:0][PC_W-1:0]     out_pc,
    input  logic [1:0]                         deq_num,
    output logic [$clog2(IQ_DEPTH):0]          iq_count
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    if (IQ_DEPTH < 8 || (IQ_DEPTH & (IQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("IQ_DEPTH must be a power of two and at least 8");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    fetch_state_t                          state_q;
    logic [PC_W-1:0]                       pc_q;
    logic                                  enq;
    logic [FETCH_WIDTH-1:0][PC_W-1:0]      enq_pc;
    logic                                  unused_redirect_lsb;

    // Full check looks at current occupancy only; a same-cycle dequeue does not make room.
    assign enq = (state_q == RUN) && !redirect_valid &&
                 (iq_count <= CW'(IQ_DEPTH - FETCH_WIDTH));

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_enq_pc
        assign enq_pc[k] = pc_q + PC_W'(4 * k);
    end

    assign icache_pc           = pc_q;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            state_q <= FLUSH;
            pc_q    <= {redirect_pc[PC_W-1:2], 2'b00};
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                FLUSH:   state_q <= RUN;
                RUN: begin
                    if (enq) pc_q <= pc_q + PC_W'(16);
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .enq_i      (enq),
        .enq_pc_i   (enq_pc),
        .enq_inst_i (icache_inst),
        .deq_num_i  (deq_num),
        .rd_pc_o    (out_pc),
        .rd_inst_o  (out_inst),
        .count_o    (iq_count)
    );

    assign out_valid[0] = (iq_count != '0) && !redirect_valid;
    assign out_valid[1] = (iq_count > CW'(1)) && !redirect_valid;

`ifndef SYNTHESIS
    logic [1:0] valid_cnt;
    assign valid_cnt = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};

    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid) begin
            assert (deq_num <= valid_cnt)
                else $error("deq_num %0d exceeds valid decode slots %0d", deq_num, valid_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-based reference model predicts every presented slot.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int DEPTH = 16;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [31:0]                        icache_pc, icache_pc2;
    logic [3:0][31:0]                   icache_inst, icache_inst2;
    logic                               redirect_valid;
    logic [31:0]                        redirect_pc;
    logic [1:0]                         out_valid, out_valid2;
    logic [1:0][31:0]                   out_inst, out_inst2, out_pc, out_pc2;
    logic [1:0]                         deq_num;
    logic [4:0]                         iq_count, iq_count2;

    fetch_ctrl #(.RESET_PC(32'h0), .IQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .icache_pc(icache_pc), .icache_inst(icache_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .deq_num(deq_num), .iq_count(iq_count));

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF0), .IQ_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .icache_pc(icache_pc2), .icache_inst(icache_inst2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_inst(out_inst2), .out_pc(out_pc2),
        .deq_num(2'd0), .iq_count(iq_count2));

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  rom = 32'h3401_0001;
            32'h04:  rom = 32'h3402_0001;
            32'h08:  rom = 32'h3403_0000;
            32'h0C:  rom = 32'h2404_0000;
            32'h10:  rom = 32'h2405_0001;
            32'h14:  rom = 32'h2406_0008;
            default: rom = (a < 32'h40) ? 32'h0 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
        endcase
    endfunction

    always_comb begin
        icache_inst  = '0;
        icache_inst2 = '0;
        for (int k = 0; k < 4; k++) begin
            icache_inst[k]  = rom(icache_pc + 32'(4 * k));
            icache_inst2[k] = rom(icache_pc2 + 32'(4 * k));
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds exactly what the IQ should hold, oldest first.
    iq_entry_t   exp_q[$];
    logic [31:0] mpc;
    int          stall;
    bit          started = 0;

    task automatic model_edge();
        bit fetch;
        if (!rst_n) begin
            exp_q.delete();
            mpc   = 32'h0;
            stall = 1;
        end else if (redirect_valid) begin
            exp_q.delete();
            mpc   = {redirect_pc[31:2], 2'b00};
            stall = 1;
        end else begin
            fetch = (stall == 0) && (exp_q.size() <= DEPTH - 4);
            for (int i = 0; i < int'(deq_num); i++) void'(exp_q.pop_front());
            if (stall > 0) stall--;
            else if (fetch) begin
                for (int k = 0; k < 4; k++) exp_q.push_back('{pc: mpc + 32'(4 * k), inst: rom(mpc + 32'(4 * k))});
                mpc = mpc + 32'd16;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        started = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [1:0] ev;
            ev[0] = !redirect_valid && (exp_q.size() > 0);
            ev[1] = !redirect_valid && (exp_q.size() > 1);
            chk("iq_count", 32'(iq_count), 32'(exp_q.size()));
            chk("icache_pc", icache_pc, mpc);
            chk("out_valid", 32'(out_valid), 32'(ev));
            for (int i = 0; i < 2; i++) begin
                if (ev[i]) begin
                    chk("slot_pc", out_pc[i], exp_q[i].pc);
                    chk("slot_inst", out_inst[i], exp_q[i].inst);
                end
            end
        end
    end

    int dn_max;

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq_num = 2'd0;

        // reset, boot, first fetch
        cyc(); cyc();
        chk("rst_icache_pc", icache_pc, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_iq_count", 32'(iq_count), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("boot_iq_count", 32'(iq_count), 32'h0);
        cyc();
        chk("first_enq_count", 32'(iq_count), 32'h4);
        chk("first_enq_pc", icache_pc, 32'h10);

        // fill and hold
        for (int n = 2; n <= 6; n++) begin
            cyc();
            chk("fill_count", 32'(iq_count), 32'((n < 4 ? n : 4) * 4));
        end
        chk("fill_icache_pc", icache_pc, 32'h40);

        // streaming
        chk("stream_inst0", out_inst[0], 32'h3401_0001);
        chk("stream_inst1", out_inst[1], 32'h3402_0001);
        deq_num = 2'd2; cyc();
        chk("stream_inst2", out_inst[0], 32'h3403_0000);
        chk("stream_inst3", out_inst[1], 32'h2404_0000);
        cyc();
        chk("stream_inst4", out_inst[0], 32'h2405_0001);
        chk("stream_inst5", out_inst[1], 32'h2406_0008);
        cyc();
        chk("stream_inst6", out_inst[0], 32'h0);
        for (int n = 0; n < 10; n++) begin
            deq_num = (exp_q.size() >= 2) ? 2'd2 : 2'(exp_q.size());
            cyc();
        end
        deq_num = 2'd0;

        // reach occupancy 10 then redirect
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        for (int n = 0; n < 10 && iq_count != 5'd10; n++) begin
            deq_num = (exp_q.size() == 8) ? 2'd2 : 2'd0;
            cyc();
        end
        deq_num = 2'd0;
        chk("pre_redirect_count", 32'(iq_count), 32'd10);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1 chk("redirect_suppress", 32'(out_valid), 32'h0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("flush_count", 32'(iq_count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_pc", icache_pc, 32'h100);
        chk("flush_state", 32'(dut.state_q), 32'(FLUSH));
        cyc();
        chk("post_flush_state", 32'(dut.state_q), 32'(RUN));
        cyc();
        chk("redirect_enq_count", 32'(iq_count), 32'h4);
        chk("redirect_enq_pc0", out_pc[0], 32'h100);
        chk("redirect_enq_pc1", out_pc[1], 32'h104);

        // back-to-back redirect
        redirect_valid = 1'b1; redirect_pc = 32'h200; cyc();
        redirect_pc = 32'h301; cyc();
        redirect_valid = 1'b0;
        #1;
        chk("rr_pc", icache_pc, 32'h300);
        chk("rr_state", 32'(dut.state_q), 32'(FLUSH));
        cyc(); cyc();
        chk("rr_head_pc", out_pc[0], 32'h300);

        // reset colliding with redirect, mid-operation
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
        cyc();
        rst_n = 1'b1; redirect_valid = 1'b0;
        #1;
        chk("coll_pc", icache_pc, 32'h0);
        chk("coll_state", 32'(dut.state_q), 32'(BOOT));
        chk("coll_count", 32'(iq_count), 32'h0);
        cyc(); cyc();
        chk("wrap_rst_second_pc", icache_pc2, 32'h0);
        chk("wrap_rst_count", 32'(iq_count2), 32'h4);
        chk("wrap_rst_pc0", out_pc2[0], 32'hFFFF_FFF0);
        chk("wrap_rst_pc1", out_pc2[1], 32'hFFFF_FFF4);
        cyc();
        chk("wrap_rst_third_pc", icache_pc2, 32'h10);
        chk("wrap_rst_head_inst", out_inst2[0], rom(32'hFFFF_FFF0));

        // randomized traffic with occasional redirects, including near-wrap targets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFE3 : $urandom;
                deq_num        = 2'd0;
            end else begin
                redirect_valid = 1'b0;
                dn_max         = (exp_q.size() < 2) ? exp_q.size() : 2;
                deq_num        = 2'($urandom_range(0, dn_max));
            end
            cyc();
        end
        redirect_valid = 1'b0; deq_num = 2'd0;
        cyc();

        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
